// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM encoding
// and byte/half lane select and insert helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_MERGE, S_WRITE, S_DONE
  } state_t;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] lane);
    logic [31:0] sh;
    sh = w >> {lane, 3'b000};
    return sh[7:0];
  endfunction

  function automatic logic [15:0] half_sel(input logic [31:0] w, input logic hi);
    return hi ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] byte_put(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (lane)
      2'd0: r[7:0]   = b;
      2'd1: r[15:8]  = b;
      2'd2: r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] half_put(input logic [31:0] w, input logic hi,
                                           input logic [15:0] h);
    return hi ? {h, w[15:0]} : {w[31:16], h};
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract with sign/zero extension and the
// sub-word store merge used by the read-modify-write path.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] read_word,
  input  logic [31:0] store_word,
  output logic [31:0] load_value,
  output logic [31:0] merge_value
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = byte_sel(read_word, lane);
  assign h = half_sel(read_word, lane[1]);

  always_comb begin
    load_value = read_word;
    case (funct3)
      F3_B:    load_value = {{24{b[7]}}, b};
      F3_BU:   load_value = {24'h0, b};
      F3_H:    load_value = {{16{h[15]}}, h};
      F3_HU:   load_value = {16'h0, h};
      default: load_value = read_word;
    endcase
  end

  always_comb begin
    merge_value = read_word;
    case (funct3)
      F3_B:    merge_value = byte_put(read_word, lane, store_word[7:0]);
      F3_H:    merge_value = half_put(read_word, lane[1], store_word[15:0]);
      default: merge_value = read_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit over a word-indexed memory with read-modify-write for SB/SH.
// Optional macro LSU_MISALIGN_CHECK_EN: misaligned H/W accesses fault instead of being aligned.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int IDX_W     = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Start,
  input  logic        MemOp,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Address,
  input  logic [31:0] StoreData,
  output logic [31:0] LoadData,
  output logic        Busy,
  output logic        Done,
  output logic        Fault,
  output logic        MemWriteEnable,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  input  logic [31:0] MemReadData
);

  state_t             state;
  logic               store_q;
  logic [2:0]         f3_q;
  logic [1:0]         lane_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        sdata_q;
  logic [31:0]        load_value;
  logic [31:0]        merge_value;
  logic               misaligned;
  logic               req_fault;
  logic               addr_unused;

  assign addr_unused = ^Address[31:IDX_W+2];

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = ((Funct3 == F3_H || Funct3 == F3_HU) && Address[0]) ||
                      (Funct3 == F3_W && Address[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  function automatic logic bad_funct3(input logic st, input logic [2:0] f3);
    if (st) return !(f3 inside {F3_B, F3_H, F3_W});
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

  // Misaligned low bits are forced to natural alignment; in the checking build
  // such requests never reach the datapath, so this is harmless there.
  function automatic logic [1:0] align_lane(input logic [2:0] f3, input logic [1:0] a);
    if (f3 == F3_H || f3 == F3_HU) return {a[1], 1'b0};
    if (f3 == F3_W) return 2'b00;
    return a;
  endfunction

  assign req_fault = bad_funct3(MemOp, Funct3) || misaligned;

  lsu_lane_align u_align (
    .funct3      (f3_q),
    .lane        (lane_q),
    .read_word   (MemReadData),
    .store_word  (sdata_q),
    .load_value  (load_value),
    .merge_value (merge_value)
  );

  always_ff @(posedge CLK) begin
    if (Start && state == S_IDLE) begin
      store_q <= MemOp;
      f3_q    <= Funct3;
      lane_q  <= align_lane(Funct3, Address[1:0]);
      idx_q   <= Address[IDX_W+1:2];
      sdata_q <= StoreData;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      Done     <= 1'b0;
      Fault    <= 1'b0;
      LoadData <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            Fault    <= req_fault;
            LoadData <= 32'h0;
            if (req_fault) begin
              state <= S_DONE;
              Done  <= 1'b1;
            end else if (MemOp && Funct3 == F3_W) begin
              state <= S_WRITE;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ:    state <= store_q ? S_MERGE : S_CAPTURE;
        S_CAPTURE: begin
          LoadData <= load_value;
          state    <= S_DONE;
          Done     <= 1'b1;
        end
        S_MERGE, S_WRITE: begin
          state <= S_DONE;
          Done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          Done  <= 1'b0;
        end
      endcase
    end
  end

  // Write strobe is gated by RESET so a reset landing in MERGE/WRITE commits nothing.
  assign Busy           = (state != S_IDLE);
  assign MemWriteEnable = (state == S_MERGE || state == S_WRITE) && !RESET;
  assign MemAddress     = 32'(idx_q & IDX_W'(MEM_WORDS - 1));

  always_comb begin
    MemWriteData = 32'h0;
    if (!RESET) begin
      if (state == S_MERGE)      MemWriteData = merge_value;
      else if (state == S_WRITE) MemWriteData = sdata_q;
    end
  end

endmodule
